// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and segment table for the seg_scan display scanner
// Contents: DIGITS, SEG_OFF, CTRL_OFF, SEG_TABLE (hex -> g..a segment pattern)
package seg_pkg;

  localparam int DIGITS = 6;

  localparam logic [7:0] SEG_OFF  = 8'h00;
  localparam logic [5:0] CTRL_OFF = 6'h3F;

  // Entry n is the active-high g..a pattern for hex digit n (entry 15 first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - load/display signal bundle for seg_scan
// master: drives load, digit_data, dp; observes seg, ctrl, frame_done, pending
// slave : the scanner side (seg_scan)
interface seg_scan_if;
  import seg_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     dp;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     ctrl;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output load, digit_data, dp,
    input  seg, ctrl, frame_done, pending
  );

  modport slave (
    input  load, digit_data, dp,
    output seg, ctrl, frame_done, pending
  );

endinterface

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex-to-7-segment decoder with blank and dp
// hex   : 4-bit digit value
// blank : force g..a off (leading-zero blanking)
// dp    : decimal point, passed to seg[7]
// seg   : active-high {dp, g..a}
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, blank ? 7'h00 : SEG_TABLE[hex]};

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed 6-digit 7-segment scanner with double-buffered load
// ck     : system clock, rising edge
// reset  : asynchronous active-low reset
// bus    : seg_scan_if.slave (load, digit_data, dp in; seg, ctrl, frame_done, pending out)
// Build option: SEG_SCAN_BLANK_EN enables leading-zero blanking of digits 1..5.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 10000,
  parameter int DIGITS  = 6
) (
  input  logic        ck,
  input  logic        reset,
  seg_scan_if.slave   bus
);

  localparam logic [15:0] DIV_MAX  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] stage_data_q, stage_data_d;
  logic [5:0]  stage_dp_q, stage_dp_d;
  logic [23:0] disp_data_q, disp_data_d;
  logic [5:0]  disp_dp_q, disp_dp_d;
  logic        pending_q, pending_d;
  logic [7:0]  seg_q, seg_d;
  logic [5:0]  ctrl_q, ctrl_d;

  logic        tick;
  logic        frame;
  logic [3:0]  act_hex;
  logic        act_dp;
  logic        act_blank;
  logic [7:0]  dec_seg;

  always_comb begin
    tick  = (cnt_q == DIV_MAX);
    frame = tick && (idx_q == LAST_IDX);

    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end

    // Transfer reads the pre-edge staging, so a load in the boundary cycle
    // is staged for the next frame rather than displayed now.
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (frame && pending_q) begin
      disp_data_d = stage_data_q;
      disp_dp_d   = stage_dp_q;
      pending_d   = 1'b0;
    end

    stage_data_d = stage_data_q;
    stage_dp_d   = stage_dp_q;
    if (bus.load) begin
      stage_data_d = bus.digit_data;
      stage_dp_d   = bus.dp;
      pending_d    = 1'b1;
    end

    act_hex = disp_data_q[{idx_q, 2'b00} +: 4];
    act_dp  = disp_dp_q[idx_q];

`ifdef SEG_SCAN_BLANK_EN
    // Blank when this digit and every higher one are zero; digit 0 always shows.
    act_blank = (idx_q != 3'd0) && ((disp_data_q >> {idx_q, 2'b00}) == 24'h0);
`else
    act_blank = 1'b0;
`endif

    seg_d  = dec_seg;
    ctrl_d = ~(6'h01 << idx_q);
  end

  seg_decode u_decode (
    .hex   (act_hex),
    .blank (act_blank),
    .dp    (act_dp),
    .seg   (dec_seg)
  );

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      cnt_q        <= 16'd0;
      idx_q        <= 3'd0;
      stage_data_q <= 24'h0;
      stage_dp_q   <= 6'h0;
      disp_data_q  <= 24'h0;
      disp_dp_q    <= 6'h0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      ctrl_q       <= CTRL_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_data_q <= stage_data_d;
      stage_dp_q   <= stage_dp_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.frame_done = frame;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan with CLK_DIV = 4
// Honours SEG_SCAN_BLANK_EN for the expected values of zero high digits.
module tb_seg_scan;

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [7:0] EXP_ZERO_HI = 8'h00;
  localparam logic [7:0] EXP_ZERO_DP = 8'h80;
`else
  localparam logic [7:0] EXP_ZERO_HI = 8'h3F;
  localparam logic [7:0] EXP_ZERO_DP = 8'hBF;
`endif

  logic ck = 1'b0;
  logic reset = 1'b0;
  int   k;
  int   n_tests = 0;
  int   n_fail = 0;

  seg_scan_if bus_if ();

  seg_scan #(.CLK_DIV(4), .DIGITS(6)) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // k counts negedges after reset release; k=0 follows the first active edge.
  task automatic step();
    @(negedge ck);
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p);
    bus_if.load       = 1'b1;
    bus_if.digit_data = d;
    bus_if.dp         = p;
    step();
    bus_if.load       = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    k = -1;
    step();
  endtask

  initial begin
    logic [5:0] exp_ctrl;
    logic [7:0] exp_seg;
    int         slot;

    bus_if.load       = 1'b0;
    bus_if.digit_data = 24'h0;
    bus_if.dp         = 6'h0;
    k = 0;

    repeat (3) @(negedge ck);
    check_eq("rst_ctrl", bus_if.ctrl, 6'h3F);
    check_eq("rst_seg", bus_if.seg, 8'h00);
    check_eq("rst_pending", bus_if.pending, 1'b0);
    check_eq("rst_frame_done", bus_if.frame_done, 1'b0);

    release_reset();
    check_eq("first_ctrl", bus_if.ctrl, 6'h3E);
    check_eq("first_seg", bus_if.seg, 8'h3F);

    // Two full frames of scanning over an all-zero display.
    for (int i = 0; i < 48; i++) begin
      run_to(i);
      slot     = (i / 4) % 6;
      exp_ctrl = 6'h3F ^ (6'h01 << slot);
      exp_seg  = (slot == 0) ? 8'h3F : EXP_ZERO_HI;
      check_eq("scan_ctrl", bus_if.ctrl, exp_ctrl);
      check_eq("scan_seg", bus_if.seg, exp_seg);
      check_eq("scan_frame_done", bus_if.frame_done, (i % 24 == 22) ? 1 : 0);
    end

    // Mid-frame load: held in staging until the boundary at k=70.
    run_to(50);
    do_load(24'h12345F, 6'b000001);
    check_eq("load_pending", bus_if.pending, 1'b1);
    run_to(64);
    check_eq("load_old_d4", bus_if.seg, EXP_ZERO_HI);
    run_to(70);
    check_eq("load_pending_bnd", bus_if.pending, 1'b1);
    check_eq("load_frame_done", bus_if.frame_done, 1'b1);
    run_to(71);
    check_eq("load_pending_clr", bus_if.pending, 1'b0);
    run_to(72);
    check_eq("new_d0_ctrl", bus_if.ctrl, 6'h3E);
    check_eq("new_d0_seg", bus_if.seg, 8'hF1);
    run_to(76);
    check_eq("new_d1_seg", bus_if.seg, 8'h6D);
    run_to(88);
    check_eq("new_d4_seg", bus_if.seg, 8'h5B);
    run_to(92);
    check_eq("new_d5_ctrl", bus_if.ctrl, 6'h1F);
    check_eq("new_d5_seg", bus_if.seg, 8'h06);

    // Load A in the boundary cycle, overwrite with B before the next one.
    run_to(118);
    check_eq("col_frame_done", bus_if.frame_done, 1'b1);
    check_eq("col_pending0", bus_if.pending, 1'b0);
    do_load(24'h888888, 6'b000000);
    check_eq("col_pending_a", bus_if.pending, 1'b1);
    run_to(120);
    check_eq("col_old_d0", bus_if.seg, 8'hF1);
    run_to(122);
    do_load(24'h00000A, 6'b100000);
    run_to(132);
    check_eq("col_old_d3", bus_if.seg, 8'h4F);
    run_to(142);
    check_eq("col_pending_bnd", bus_if.pending, 1'b1);
    run_to(143);
    check_eq("col_pending_clr", bus_if.pending, 1'b0);
    run_to(144);
    check_eq("col_b_d0", bus_if.seg, 8'h77);
    run_to(148);
    check_eq("col_b_d1", bus_if.seg, EXP_ZERO_HI);
    run_to(164);
    check_eq("col_b_d5", bus_if.seg, EXP_ZERO_DP);

    // Load while pending, then load again in the boundary cycle.
    run_to(150);
    do_load(24'h000001, 6'b000000);
    run_to(166);
    check_eq("bnd_frame_done", bus_if.frame_done, 1'b1);
    do_load(24'h00000E, 6'b000000);
    check_eq("bnd_pending_kept", bus_if.pending, 1'b1);
    run_to(168);
    check_eq("bnd_c_d0", bus_if.seg, 8'h06);

    // Asynchronous reset with data pending; staged data must be lost.
    run_to(170);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", bus_if.ctrl, 6'h3F);
    check_eq("mid_rst_seg", bus_if.seg, 8'h00);
    check_eq("mid_rst_pending", bus_if.pending, 1'b0);
    repeat (2) @(negedge ck);
    release_reset();
    check_eq("post_rst_ctrl", bus_if.ctrl, 6'h3E);
    check_eq("post_rst_seg", bus_if.seg, 8'h3F);
    check_eq("post_rst_pending", bus_if.pending, 1'b0);
    run_to(23);
    check_eq("post_rst_pending_f", bus_if.pending, 1'b0);
    run_to(24);
    check_eq("post_rst_d0", bus_if.seg, 8'h3F);
    run_to(28);
    check_eq("post_rst_d1", bus_if.seg, EXP_ZERO_HI);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
